timer_gen: RTL and testbench
============================

TIMER_GEN -- requirements
Module: timer_gen

Interface
REQ-001 Parameter CLK_MHZ, default 125, clock frequency in integer MHz, legal range 2..255.
REQ-002 Parameter N_CH, default 4, number of programmable interval channels, legal range 1..8.
REQ-003 Parameter CW, default 16, channel interval width in ms units, legal range 2..24.
REQ-004 CLK  in  1  system clock; the block SHALL use this single clock only.
REQ-005 RST  in  1  system reset, asynchronous, active-high.
REQ-006 SYNC_CLR  in  1  synchronous restart of the prescaler chain.
REQ-007 TIM_1US / TIM_1MS / TIM_1S / TIM_1M  out  1 each  one-cycle interval pulses.
REQ-008 UPTIME_S  out  32  seconds elapsed since reset.
REQ-009 CH_LOAD  in  N_CH  per-channel load/start strobe.
REQ-010 CH_VALUE  in  N_CH*CW  interval in ms; channel i at bits [i*CW +: CW].
REQ-011 CH_PERIODIC  in  N_CH  mode sampled on load: 1 periodic, 0 one-shot.
REQ-012 CH_STOP  in  N_CH  per-channel stop strobe.
REQ-013 CH_EXPIRE  out  N_CH  one-cycle expiry pulse per channel.
REQ-014 CH_BUSY  out  N_CH  channel in RUN state.

Function
REQ-015 The us prescaler SHALL count CLK_MHZ cycles; the internal us tick SHALL occur once every exactly CLK_MHZ cycles.
REQ-016 The ms tick SHALL coincide with every 1000th us tick, the s tick with every 1000th ms tick, and the min tick with every 60th s tick.
REQ-017 All TIM_* outputs SHALL be registered, high for exactly one cycle, one cycle after the internal tick; coincident ticks SHALL assert in the same cycle.
REQ-018 The first TIM_1US SHALL be high in cycle CLK_MHZ+1 after the first rising edge following RST deassertion (edge 1 = cycle 1), then every CLK_MHZ cycles.
REQ-019 SYNC_CLR SHALL return all prescaler counters to their reset value and suppress any tick in that cycle; UPTIME_S and channel states SHALL be unaffected.
REQ-020 UPTIME_S SHALL increment by 1 in the same cycle TIM_1S is high and wrap 0xFFFFFFFF -> 0.
REQ-021 Each channel SHALL be an independent FSM with states IDLE and RUN, holding a CW-bit counter and a CW-bit reload register.
REQ-022 CH_LOAD with value V>0 SHALL set counter=V, reload=V, latch mode, and enter RUN; V=0 SHALL force IDLE without expiry.
REQ-023 In RUN, each ms tick SHALL decrement the counter; the ms tick at counter=1 SHALL raise CH_EXPIRE in the same cycle as TIM_1MS.
REQ-024 On expiry, a periodic channel SHALL reload counter=reload and stay in RUN; a one-shot channel SHALL go to IDLE.
REQ-025 CH_STOP SHALL force IDLE without expiry; in IDLE, ms ticks SHALL be ignored.
REQ-026 Per-channel priority SHALL be RST > CH_LOAD > CH_STOP > ms-tick decrement; a load in the expiry cycle SHALL cancel that expiry.
REQ-027 The first expiry after a load SHALL occur on the V-th ms tick after the load cycle, i.e. between V-1 and V ms later.
REQ-028 CH_BUSY SHALL equal (state == RUN), registered.

Reset
REQ-029 RST SHALL asynchronously clear all prescalers, UPTIME_S, all channel counters, reload registers, and mode bits, and SHALL put every channel in IDLE.
REQ-030 During and immediately after reset, all TIM_*, CH_EXPIRE, and CH_BUSY outputs SHALL be 0 and UPTIME_S SHALL be 0.
REQ-031 Reset asserted mid-run SHALL drop any pending pulse with no partial-cycle output.

Verification (CLK_MHZ=2 unless stated)
REQ-032 Release reset, free-run -> TIM_1US in cycle 3 then every 2; TIM_1MS every 2000 cycles; TIM_1S every 2,000,000 cycles.
REQ-033 Run 61 s -> TIM_1M exactly once, in the same cycle as the 60th TIM_1S, TIM_1MS, and TIM_1US; UPTIME_S=60 after it.
REQ-034 Channel 0 load V=3 one-shot -> CH_BUSY=1; CH_EXPIRE[0] once on the 3rd TIM_1MS; then CH_BUSY=0, with no further pulses.
REQ-035 Channel 1 load V=2 periodic, run 10 ms -> CH_EXPIRE[1] on every 2nd TIM_1MS (5 pulses); CH_STOP -> no further pulses.
REQ-036 Load issued in the cycle of a pending expiry -> no CH_EXPIRE, counter=new V; SYNC_CLR pulse -> next TIM_1US 3 cycles later, UPTIME_S unchanged.
REQ-037 Preload UPTIME_S near wrap via force, cross 0xFFFFFFFF -> wraps to 0; assert RST mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/timer_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// timer_gen
//
// Free-running timebase plus a bank of programmable millisecond interval
// channels, all in the single CLK domain.
//
// A prescaler chain divides CLK down to 1 us, 1 ms, 1 s and 1 min ticks.
// Each tick is registered onto its TIM_* output, so every pulse is one CLK
// wide and appears one cycle after the internal tick. Coincident ticks
// (e.g. the us/ms/s/min boundary) come out in the same cycle. UPTIME_S counts
// seconds since reset and steps in the same cycle TIM_1S is high.
//
// Each channel is a small IDLE/RUN FSM with a down counter and a reload
// register. In RUN, every internal ms tick decrements the counter. The tick
// that sees counter==1 raises CH_EXPIRE, which is registered like TIM_1MS and
// therefore lines up with it. Periodic channels reload; one-shot channels
// return to IDLE.
//
// Parameters
//   CLK_MHZ  clock frequency in integer MHz (2..255)
//   N_CH     number of interval channels (1..8)
//   CW       channel interval width in ms units (2..24)
//
// Ports
//   CLK          in   system clock
//   RST          in   asynchronous active-high reset
//   SYNC_CLR     in   synchronous restart of the prescaler chain
//   TIM_1US      out  one-cycle pulse every microsecond
//   TIM_1MS      out  one-cycle pulse every millisecond
//   TIM_1S       out  one-cycle pulse every second
//   TIM_1M       out  one-cycle pulse every minute
//   UPTIME_S     out  seconds since reset, wraps at 2^32
//   CH_LOAD      in   per-channel load/start strobe
//   CH_VALUE     in   per-channel interval in ms, channel i at [i*CW +: CW]
//   CH_PERIODIC  in   per-channel mode sampled on load (1 periodic, 0 one-shot)
//   CH_STOP      in   per-channel stop strobe
//   CH_EXPIRE    out  per-channel one-cycle expiry pulse
//   CH_BUSY      out  per-channel "in RUN state"
// -----------------------------------------------------------------------------
module timer_gen #(
    parameter int CLK_MHZ = 125,
    parameter int N_CH    = 4,
    parameter int CW      = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SYNC_CLR,
    output logic                 TIM_1US,
    output logic                 TIM_1MS,
    output logic                 TIM_1S,
    output logic                 TIM_1M,
    output logic [31:0]          UPTIME_S,
    input  logic [N_CH-1:0]      CH_LOAD,
    input  logic [N_CH*CW-1:0]   CH_VALUE,
    input  logic [N_CH-1:0]      CH_PERIODIC,
    input  logic [N_CH-1:0]      CH_STOP,
    output logic [N_CH-1:0]      CH_EXPIRE,
    output logic [N_CH-1:0]      CH_BUSY
);

    // -------------------------------------------------------------------------
    // Prescaler chain
    // -------------------------------------------------------------------------
    // The us counter idles at 0 after reset/clear and then cycles 1..CLK_MHZ.
    // Starting from 0 rather than 1 delays the first tick by exactly one
    // cycle. As a result, the first TIM_1US lands in cycle CLK_MHZ+1 after
    // reset release. It also lands CLK_MHZ+1 cycles after a SYNC_CLR edge.
    localparam logic [7:0] US_TERM = 8'(CLK_MHZ);

    logic [7:0]  cnt_us;
    logic [9:0]  cnt_ms;
    logic [9:0]  cnt_s;
    logic [5:0]  cnt_min;
    logic [31:0] uptime_q;

    logic us_term;
    logic tick_us;
    logic tick_ms;
    logic tick_s;
    logic tick_m;

    assign us_term = (cnt_us == US_TERM);

    // SYNC_CLR masks the whole chain so no tick escapes in the clear cycle.
    assign tick_us = us_term & ~SYNC_CLR;
    assign tick_ms = tick_us & (cnt_ms == 10'd999);
    assign tick_s  = tick_ms & (cnt_s == 10'd999);
    assign tick_m  = tick_s & (cnt_min == 6'd59);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_us  <= '0;
            cnt_ms  <= '0;
            cnt_s   <= '0;
            cnt_min <= '0;
        end else if (SYNC_CLR) begin
            cnt_us  <= '0;
            cnt_ms  <= '0;
            cnt_s   <= '0;
            cnt_min <= '0;
        end else begin
            cnt_us <= us_term ? 8'd1 : cnt_us + 8'd1;
            if (tick_us) begin
                cnt_ms <= (cnt_ms == 10'd999) ? 10'd0 : cnt_ms + 10'd1;
            end
            if (tick_ms) begin
                cnt_s <= (cnt_s == 10'd999) ? 10'd0 : cnt_s + 10'd1;
            end
            if (tick_s) begin
                cnt_min <= (cnt_min == 6'd59) ? 6'd0 : cnt_min + 6'd1;
            end
        end
    end

    // Registered pulse outputs and uptime. Uptime is not touched by SYNC_CLR;
    // the gated tick_s already keeps it from stepping in a clear cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TIM_1US  <= 1'b0;
            TIM_1MS  <= 1'b0;
            TIM_1S   <= 1'b0;
            TIM_1M   <= 1'b0;
            uptime_q <= '0;
        end else begin
            TIM_1US <= tick_us;
            TIM_1MS <= tick_ms;
            TIM_1S  <= tick_s;
            TIM_1M  <= tick_m;
            if (tick_s) begin
                uptime_q <= uptime_q + 32'd1;
            end
        end
    end

    assign UPTIME_S = uptime_q;

    // -------------------------------------------------------------------------
    // Interval channels
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    ch_state_t       state_q  [N_CH];
    ch_state_t       state_d  [N_CH];
    logic [CW-1:0]   cnt_q    [N_CH];
    logic [CW-1:0]   cnt_d    [N_CH];
    logic [CW-1:0]   reload_q [N_CH];
    logic [CW-1:0]   reload_d [N_CH];
    logic [N_CH-1:0] mode_q;
    logic [N_CH-1:0] mode_d;
    logic [N_CH-1:0] expire_d;
    logic [N_CH-1:0] expire_q;

    // Next-state logic. Per channel the priority is load, then stop, then the
    // ms-tick decrement. Because load wins, a load that arrives with the
    // expiring tick discards that expiry and restarts the count.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            reload_d[i] = reload_q[i];
            mode_d[i]   = mode_q[i];
            expire_d[i] = 1'b0;

            if (CH_LOAD[i]) begin
                if (CH_VALUE[i*CW +: CW] != '0) begin
                    state_d[i]  = ST_RUN;
                    cnt_d[i]    = CH_VALUE[i*CW +: CW];
                    reload_d[i] = CH_VALUE[i*CW +: CW];
                    mode_d[i]   = CH_PERIODIC[i];
                end else begin
                    // A zero interval is a silent cancel.
                    state_d[i] = ST_IDLE;
                end
            end else if (CH_STOP[i]) begin
                state_d[i] = ST_IDLE;
            end else if ((state_q[i] == ST_RUN) && tick_ms) begin
                if (cnt_q[i] == CW'(1)) begin
                    expire_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        cnt_d[i] = reload_q[i];
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
            end
            mode_q   <= '0;
            expire_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                reload_q[i] <= reload_d[i];
            end
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    // Expiry is registered alongside TIM_1MS. Busy decodes the state register
    // directly, so it is glitch-free.
    assign CH_EXPIRE = expire_q;

    always_comb begin
        CH_BUSY = '0;
        for (int i = 0; i < N_CH; i++) begin
            CH_BUSY[i] = (state_q[i] == ST_RUN);
        end
    end

endmodule

// File: tb/tb_timer_gen.sv
`timescale 1ns/1ps
module tb_timer_gen;

    localparam int CLK_MHZ = 2;
    localparam int N_CH    = 4;
    localparam int CW      = 16;

    logic                 CLK;
    logic                 RST;
    logic                 SYNC_CLR;
    logic                 TIM_1US;
    logic                 TIM_1MS;
    logic                 TIM_1S;
    logic                 TIM_1M;
    logic [31:0]          UPTIME_S;
    logic [N_CH-1:0]      CH_LOAD;
    logic [N_CH*CW-1:0]   CH_VALUE;
    logic [N_CH-1:0]      CH_PERIODIC;
    logic [N_CH-1:0]      CH_STOP;
    logic [N_CH-1:0]      CH_EXPIRE;
    logic [N_CH-1:0]      CH_BUSY;

    timer_gen #(.CLK_MHZ(CLK_MHZ), .N_CH(N_CH), .CW(CW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SYNC_CLR    (SYNC_CLR),
        .TIM_1US     (TIM_1US),
        .TIM_1MS     (TIM_1MS),
        .TIM_1S      (TIM_1S),
        .TIM_1M      (TIM_1M),
        .UPTIME_S    (UPTIME_S),
        .CH_LOAD     (CH_LOAD),
        .CH_VALUE    (CH_VALUE),
        .CH_PERIODIC (CH_PERIODIC),
        .CH_STOP     (CH_STOP),
        .CH_EXPIRE   (CH_EXPIRE),
        .CH_BUSY     (CH_BUSY)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // cyc == k while in cycle k (edge 1 is the first posedge after release)
    int cyc;
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window observer: counts ms pulses and per-channel expiries.
    int ms_seen;
    int exp_cnt   [N_CH];
    int exp_first [N_CH];
    int misalign;

    task automatic clear_obs();
        ms_seen  = 0;
        misalign = 0;
        for (int c = 0; c < N_CH; c++) begin
            exp_cnt[c]   = 0;
            exp_first[c] = 0;
        end
    endtask

    // Samples the current negedge and the next n-1, ends on a fresh negedge.
    task automatic observe(input int n);
        for (int k = 0; k < n; k++) begin
            if (TIM_1MS) ms_seen++;
            for (int c = 0; c < N_CH; c++) begin
                if (CH_EXPIRE[c]) begin
                    exp_cnt[c]++;
                    if (exp_first[c] == 0) exp_first[c] = ms_seen;
                    if (!TIM_1MS) misalign++;
                end
            end
            @(negedge CLK);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_us();
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!TIM_1US && k < 50);
        check("us_found", 32'(TIM_1US), 32'd1);
    endtask

    task automatic wait_ms();
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!TIM_1MS && k < 2100);
        check("ms_found", 32'(TIM_1MS), 32'd1);
    endtask

    task automatic pulse_load(input int ch, input logic [CW-1:0] v, input logic per);
        CH_LOAD[ch]          = 1'b1;
        CH_VALUE[ch*CW +: CW] = v;
        CH_PERIODIC[ch]      = per;
        @(negedge CLK);
        CH_LOAD = '0;
    endtask

    task automatic pulse_stop(input int ch);
        CH_STOP[ch] = 1'b1;
        @(negedge CLK);
        CH_STOP = '0;
    endtask

    // Jump the prescaler chain to the edge of a ms/s boundary just before the
    // next us tick, with chosen minute count and uptime.
    task automatic force_tick(input logic [5:0] mn, input logic [31:0] up, input logic exp_m);
        wait_us();
        force dut.cnt_ms   = 10'd999;
        force dut.cnt_s    = 10'd999;
        force dut.cnt_min  = mn;
        force dut.uptime_q = up;
        #1;
        release dut.cnt_ms;
        release dut.cnt_s;
        release dut.cnt_min;
        release dut.uptime_q;
        @(negedge CLK);
        check("fs_pre_1s", 32'(TIM_1S), 32'd0);
        check("fs_pre_up", UPTIME_S, up);
        @(negedge CLK);
        check("fs_us", 32'(TIM_1US), 32'd1);
        check("fs_ms", 32'(TIM_1MS), 32'd1);
        check("fs_s",  32'(TIM_1S),  32'd1);
        check("fs_m",  32'(TIM_1M),  32'(exp_m));
        check("fs_up", UPTIME_S, up + 32'd1);
        @(negedge CLK);
        check("fs_m_width", 32'(TIM_1M), 32'd0);
        check("fs_s_width", 32'(TIM_1S), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d;
        logic [31:0] u0;

        RST         = 1'b1;
        SYNC_CLR    = 1'b0;
        CH_LOAD     = '0;
        CH_VALUE    = '0;
        CH_PERIODIC = '0;
        CH_STOP     = '0;

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_tim", {28'd0, TIM_1US, TIM_1MS, TIM_1S, TIM_1M}, 32'd0);
        check("rst_up", UPTIME_S, 32'd0);
        check("rst_busy", 32'(CH_BUSY), 32'd0);
        check("rst_exp", 32'(CH_EXPIRE), 32'd0);
        RST = 1'b0;

        // us cadence: cycle 3 then every 2 cycles
        wait_us();
        check("us_first_cyc", 32'(cyc), 32'd3);
        @(negedge CLK);
        check("us_width", 32'(TIM_1US), 32'd0);
        wait_us();
        check("us_second_cyc", 32'(cyc), 32'd5);
        wait_us();
        check("us_third_cyc", 32'(cyc), 32'd7);

        // ms cadence: 2000 cycles, coincident with a us pulse
        wait_ms();
        check("ms_first_cyc", 32'(cyc), 32'd2001);
        check("ms_with_us", 32'(TIM_1US), 32'd1);
        wait_ms();
        check("ms_second_cyc", 32'(cyc), 32'd4001);

        // ch0: one-shot V=3
        wait_ms();
        pulse_load(0, 16'd3, 1'b0);
        check("os_busy", 32'(CH_BUSY[0]), 32'd1);
        clear_obs();
        observe(10000);
        check("os_ms_count", 32'(ms_seen), 32'd5);
        check("os_exp_count", 32'(exp_cnt[0]), 32'd1);
        check("os_exp_at", 32'(exp_first[0]), 32'd3);
        check("os_align", 32'(misalign), 32'd0);
        check("os_busy_after", 32'(CH_BUSY[0]), 32'd0);

        // ch1: periodic V=2 for 10 ms, then stop
        wait_ms();
        pulse_load(1, 16'd2, 1'b1);
        clear_obs();
        observe(20000);
        check("per_ms_count", 32'(ms_seen), 32'd10);
        check("per_exp_count", 32'(exp_cnt[1]), 32'd5);
        check("per_exp_first", 32'(exp_first[1]), 32'd2);
        check("per_align", 32'(misalign), 32'd0);
        check("per_busy", 32'(CH_BUSY[1]), 32'd1);
        pulse_stop(1);
        check("stop_busy", 32'(CH_BUSY[1]), 32'd0);
        clear_obs();
        observe(4000);
        check("stop_exp_count", 32'(exp_cnt[1]), 32'd0);

        // ch2: reload in the cycle of the pending expiry cancels it
        wait_ms();
        pulse_load(2, 16'd1, 1'b0);
        repeat (1998) @(negedge CLK);
        pulse_load(2, 16'd2, 1'b0);
        check("cancel_ms", 32'(TIM_1MS), 32'd1);
        check("cancel_exp", 32'(CH_EXPIRE[2]), 32'd0);
        check("cancel_busy", 32'(CH_BUSY[2]), 32'd1);
        @(negedge CLK);
        clear_obs();
        observe(5000);
        check("cancel_new_count", 32'(exp_cnt[2]), 32'd1);
        check("cancel_new_at", 32'(exp_first[2]), 32'd2);
        check("cancel_busy_after", 32'(CH_BUSY[2]), 32'd0);

        // ch3: load V=0 right after a real load forces IDLE silently
        wait_ms();
        pulse_load(3, 16'd3, 1'b1);
        check("zero_busy_pre", 32'(CH_BUSY[3]), 32'd1);
        pulse_load(3, 16'd0, 1'b0);
        check("zero_busy", 32'(CH_BUSY[3]), 32'd0);
        clear_obs();
        observe(8000);
        check("zero_exp_count", 32'(exp_cnt[3]), 32'd0);

        // SYNC_CLR in a tick cycle: tick suppressed, next us pulse 3 cycles on
        wait_ms();
        pulse_load(0, 16'd2, 1'b1);
        wait_us();
        @(negedge CLK);
        u0 = UPTIME_S;
        SYNC_CLR = 1'b1;
        @(negedge CLK);
        SYNC_CLR = 1'b0;
        check("sync_suppress", 32'(TIM_1US), 32'd0);
        d = 0;
        while (!TIM_1US && d < 20) begin
            @(negedge CLK);
            d++;
        end
        check("sync_us_delay", 32'(d), 32'd3);
        check("sync_uptime", UPTIME_S, u0);
        check("sync_busy", 32'(CH_BUSY[0]), 32'd1);
        pulse_stop(0);

        // uptime wrap on a second boundary (not a minute)
        force_tick(6'd0, 32'hFFFF_FFFF, 1'b0);
        // 60th second: minute pulse coincident, uptime reaches 60
        force_tick(6'd59, 32'd59, 1'b1);

        // asynchronous reset during a live pulse
        pulse_load(1, 16'd5, 1'b1);
        wait_us();
        check("pre_rst_up", UPTIME_S, 32'd60);
        check("pre_rst_busy", 32'(CH_BUSY[1]), 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check("arst_us", 32'(TIM_1US), 32'd0);
        check("arst_up", UPTIME_S, 32'd0);
        check("arst_busy", 32'(CH_BUSY), 32'd0);
        repeat (3) @(negedge CLK);
        check("arst_hold_tim", {28'd0, TIM_1US, TIM_1MS, TIM_1S, TIM_1M}, 32'd0);
        check("arst_hold_exp", 32'(CH_EXPIRE), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
